bip_fetch_control: RTL

- Instruction-fetch and sequencing stage directly upstream of the BIP instruction decoder.
- Owns the program counter (PC), addresses the synchronous program memory and holds the current instruction in an instruction register (IR).
- Presents the 5-bit opcode to the decoder and the 11-bit operand to the datapath.
- Consumes the decoder's WrPC to advance or halt; provides execute qualification and performance counters.

---
 rtl/bip_pkg.sv | 25 ++
 rtl/bip_fetch_control_if.sv | 26 ++
 rtl/bip_sat_counter.sv | 25 ++
 rtl/bip_fetch_control.sv | 83 ++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared BIP definitions: fetch FSM state encoding, instruction field layout
// and opcode constants used by both the fetch stage and the decoder.
package bip_pkg;

  localparam int unsigned OPCODE_W  = 5;
  localparam int unsigned OPERAND_W = 11;
  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 11;

  typedef logic [1:0] state_t;
  localparam state_t FETCH = 2'd0;
  localparam state_t LOAD  = 2'd1;
  localparam state_t EXEC  = 2'd2;
  localparam state_t HALT  = 2'd3;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_STO  = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 5'd7;

endpackage

// File: rtl/bip_fetch_control_if.sv
// Program-memory and decoder bus of the BIP fetch stage.
interface bip_fetch_control_if
  import bip_pkg::*;
#(
  parameter int unsigned PC_W    = 11,
  parameter int unsigned INSTR_W = 16
);

  logic [PC_W-1:0]      prog_addr;
  logic [INSTR_W-1:0]   prog_data;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;
  logic                 exec_en;
  logic                 WrPC;

  modport master (
    output prog_addr, opcode, operand, exec_en,
    input  prog_data, WrPC
  );

  modport slave (
    input  prog_addr, opcode, operand, exec_en,
    output prog_data, WrPC
  );

endinterface

// File: rtl/bip_sat_counter.sv
// Up-counter with enable and synchronous reset that sticks at all-ones.
module bip_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bip_fetch_control.sv
// BIP fetch/sequencing stage: PC, instruction register and the
// FETCH -> LOAD -> EXEC (-> HALT) sequencer, plus performance counters.
module bip_fetch_control
  import bip_pkg::*;
#(
  parameter int unsigned PC_W    = 11,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  bip_fetch_control_if.master      bus,
  output logic [PC_W-1:0]          pc,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instr_count
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               retire;

  // WrPC only matters in EXEC; every other state ignores it entirely.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: state_d = LOAD;
      LOAD: begin
        ir_d    = bus.prog_data;
        state_d = EXEC;
      end
      EXEC: begin
        if (bus.WrPC) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end else begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign retire = (state_q == EXEC) && bus.WrPC;

  bip_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q != HALT),
    .count_o (cycle_count)
  );

  bip_sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (retire),
    .count_o (instr_count)
  );

  assign bus.prog_addr = pc_q;
  assign bus.opcode    = ir_q[OPC_MSB:OPC_LSB];
  assign bus.operand   = ir_q[OPERAND_W-1:0];
  assign bus.exec_en   = (state_q == EXEC);
  assign pc            = pc_q;
  assign halted        = (state_q == HALT);

endmodule
